// File: rtl/fdiv_seq_if.sv
// rtl/fdiv_seq_if.sv - operand/result handshake bundle for the sequential FP divider
interface fdiv_seq_if;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  x1, x2, in_valid, out_ready,
        output in_ready, y, ovf, out_valid
    );

    modport master (
        output x1, x2, in_valid, out_ready,
        input  in_ready, y, ovf, out_valid
    );
endinterface

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - multi-cycle single-precision divider, restoring radix-2, one quotient bit per cycle
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    fdiv_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    typedef enum logic [1:0] {C_NORM, C_NAN, C_INF, C_ZERO} class_t;

    state_t             state_q, state_d;
    class_t             cls_q, cls_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        quo_q, quo_d;
    logic [23:0]        m2_q, m2_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [31:0]        y_q, y_d;
    logic               ovf_q, ovf_d;

    logic [7:0]         e1, e2;
    logic [22:0]        f1, f2;
    logic [23:0]        m1, m2;
    logic               adj;
    class_t             cls_in;

    assign e1  = bus.x1[30:23];
    assign e2  = bus.x2[30:23];
    assign f1  = bus.x1[22:0];
    assign f2  = bus.x2[22:0];
    assign m1  = {1'b1, f1};
    assign m2  = {1'b1, f2};
    assign adj = (m1 < m2);

    // Special operands are classified up front; they still run the full datapath for fixed latency.
    always_comb begin
        cls_in = C_NORM;
        if ((e1 == 8'hFF && f1 != 23'd0) || (e2 == 8'hFF && f2 != 23'd0) ||
            (e1 == 8'h00 && e2 == 8'h00) || (e1 == 8'hFF && e2 == 8'hFF))
            cls_in = C_NAN;
        else if (e1 == 8'hFF || e2 == 8'h00)
            cls_in = C_INF;
        else if (e1 == 8'h00 || e2 == 8'hFF)
            cls_in = C_ZERO;
    end

    logic               q_bit;
    logic [23:0]        rem_sub;
    logic [23:0]        rem_keep;

    assign q_bit    = (rem_q >= {1'b0, m2_q});
    assign rem_sub  = rem_q[23:0] - m2_q;
    assign rem_keep = q_bit ? rem_sub : rem_q[23:0];

    // quo_q holds the 23 fraction bits plus guard; the integer bit has been shifted out.
    logic               sticky, guard, lsb, round_up;
    logic               carry;
    logic [22:0]        frac_r;
    logic signed [9:0]  exp_r;

    assign sticky   = (rem_q != 25'd0);
    assign guard    = quo_q[0];
    assign lsb      = quo_q[1];
    assign round_up = guard & (sticky | lsb);
    assign {carry, frac_r} = {1'b0, quo_q[23:1]} + {23'd0, round_up};
    assign exp_r    = exp_q + $signed({9'd0, carry});

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        m2_d    = m2_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.x1[31] ^ bus.x2[31];
                    m2_d    = m2;
                    rem_d   = adj ? {m1, 1'b0} : {1'b0, m1};
                    exp_d   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127
                              - $signed({9'd0, adj});
                    cls_d   = cls_in;
                    quo_d   = 24'd0;
                    cnt_d   = 5'd24;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = {rem_keep, 1'b0};
                quo_d = {quo_q[22:0], q_bit};
                if (cnt_q == 5'd0)
                    state_d = ROUND;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            ROUND: begin
                ovf_d = 1'b0;
                case (cls_q)
                    C_NAN:  y_d = {sign_q, 8'hFF, 23'h400000};
                    C_INF:  y_d = {sign_q, 8'hFF, 23'd0};
                    C_ZERO: y_d = {sign_q, 8'h00, 23'd0};
                    default: begin
                        if (exp_r >= 10'sd255) begin
                            y_d   = {sign_q, 8'hFF, 23'd0};
                            ovf_d = 1'b1;
                        end else if (exp_r <= 10'sd0) begin
                            y_d = {sign_q, 8'h00, 23'd0};
                        end else begin
                            y_d = {sign_q, exp_r[7:0], frac_r};
                        end
                    end
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= C_NORM;
            cnt_q   <= 5'd0;
            rem_q   <= 25'd0;
            quo_q   <= 24'd0;
            m2_q    <= 24'd0;
            exp_q   <= 10'sd0;
            sign_q  <= 1'b0;
            y_q     <= 32'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            m2_q    <= m2_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - self-checking bench for fdiv_seq: vector table, corner sequences, random sweep
module tb_fdiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fdiv_seq_if bus();

    fdiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real mag(input logic [31:0] b);
        return (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'({24'd0, b[30:23]}) - 127);
    endfunction

    // Reference: exact real quotient rounded to 24 bits (RNE), flush/overflow on the rounded exponent.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        real         q, sc, ip, fr;
        int          ex, ii, be;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'h00 && eb == 8'h00) || (ea == 8'hFF && eb == 8'hFF))
            return {1'b1, 1'b0, 32'd0};
        if (ea == 8'hFF || eb == 8'h00) return {1'b0, 1'b0, s, 8'hFF, 23'd0};
        if (ea == 8'h00 || eb == 8'hFF) return {1'b0, 1'b0, s, 8'h00, 23'd0};
        q  = mag(a) / mag(b);
        ex = 0;
        while (q >= 2.0) begin q = q / 2.0; ex++; end
        while (q < 1.0)  begin q = q * 2.0; ex--; end
        sc = q * 8388608.0;
        ip = $floor(sc);
        fr = sc - ip;
        ii = $rtoi(ip);
        if (fr > 0.5 || (fr == 0.5 && ii[0])) ii++;
        if (ii == 16777216) begin ii = 8388608; ex++; end
        be = ex + 127;
        if (be >= 255) return {1'b0, 1'b1, s, 8'hFF, 23'd0};
        if (be <= 0)   return {1'b0, 1'b0, s, 8'h00, 23'd0};
        return {1'b0, 1'b0, s, be[7:0], ii[22:0]};
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            errors++; checks++;
            $display("FAIL issue_timeout: in_ready stayed %b, expected 1", bus.in_ready);
        end
        bus.x1 = a; bus.x2 = b; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x1 = $urandom; bus.x2 = $urandom;
    endtask

    task automatic wait_result(output logic [31:0] y, output logic o, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!bus.out_valid) begin
            errors++; checks++;
            $display("FAIL result_timeout: out_valid stayed %b, expected 1", bus.out_valid);
        end
        y = bus.y; o = bus.ovf;
    endtask

    logic [31:0] ry, ya, opa, opb;
    logic        ro, stale;
    logic [33:0] r;
    int          lat;
    logic [7:0]  edge_e[8];

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        if ($urandom_range(0, 2) == 0) e = edge_e[$urandom_range(0, 7)];
        else                           e = 8'($urandom_range(0, 255));
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    initial begin
        edge_e = '{8'd0, 8'd1, 8'd2, 8'd126, 8'd127, 8'd128, 8'd254, 8'd255};
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
        vecs[2]  = '{32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0};
        vecs[3]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1};
        vecs[4]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[5]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0};
        vecs[7]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0};
        vecs[8]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0};
        vecs[9]  = '{32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 1'b0};
        vecs[10] = '{32'h40000000, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[11] = '{32'h3F7FFFFF, 32'h3F800000, 32'h3F7FFFFF, 1'b0};

        bus.x1 = 32'd0; bus.x2 = 32'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_y", bus.y, 32'd0);
        chk("reset_ovf", {31'd0, bus.ovf}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_result(ry, ro, lat);
            chk($sformatf("vec%0d_y", i), ry, vecs[i].y);
            chk($sformatf("vec%0d_ovf", i), {31'd0, ro}, {31'd0, vecs[i].ovf});
            chk($sformatf("vec%0d_latency", i), lat, 27);
        end

        // Backpressure: result held, no second accept until the consumer takes it.
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000);
        wait_result(ya, ro, lat);
        chk("bp_first_y", ya, 32'h40400000);
        for (int i = 0; i < 10; i++) begin
            bus.x1 = 32'h3F800000; bus.x2 = 32'h40400000; bus.in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_hold_y%0d", i), bus.y, ya);
            chk($sformatf("bp_hold_valid%0d", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp_hold_ready%0d", i), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(ry, ro, lat);
        chk("bp_second_y", ry, 32'h3EAAAAAB);
        chk("bp_second_latency", lat, 27);

        // Reset mid-division discards the in-flight result.
        @(negedge clk);
        issue(32'h7F000000, 32'h3E800000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_mid_y", bus.y, 32'd0);
        stale = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        chk("rst_no_stale", {31'd0, stale}, 32'd0);
        issue(32'hBF800000, 32'h40000000);
        wait_result(ry, ro, lat);
        chk("rst_after_y", ry, 32'hBF000000);
        chk("rst_after_ovf", {31'd0, ro}, 32'd0);

        // Random sweep against the real-arithmetic reference.
        for (int i = 0; i < 600; i++) begin
            opa = rnd_op();
            opb = rnd_op();
            r = ref_div(opa, opb);
            @(negedge clk);
            issue(opa, opb);
            wait_result(ry, ro, lat);
            if (!r[33]) begin
                chk($sformatf("rnd%0d_y(%h/%h)", i, opa, opb), ry, r[31:0]);
                chk($sformatf("rnd%0d_ovf(%h/%h)", i, opa, opb), {31'd0, ro}, {31'd0, r[32]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fdiv_seq.md
# fdiv_seq

Multi-cycle IEEE-754 single-precision divider for the FPU, the inverse companion to the combinational `fmul`. Computes `y = x1 / x2` with a restoring radix-2 mantissa divider, one quotient bit per cycle, behind a valid/ready handshake on both sides. Number-format rules match `fmul`: no denormals, round-to-nearest-even, `ovf` flag on exponent overflow from finite operands, NaN results don't-care. Sits in the FPU next to `fmul` and is driven by the core's FP issue logic.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `x1`  in  32  dividend, sampled on accept
- `x2`  in  32  divisor, sampled on accept
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  divider idle and accepting
- `y`  out  32  quotient, held stable while `out_valid`
- `ovf`  out  1  exponent overflow, valid with `y`
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result

## Operation
- States: IDLE, DIV, ROUND, DONE. Reset → IDLE; `y`=0, `ovf`=0, `out_valid`=0, `in_ready`=1 (IDLE only).
- IDLE: `in_valid` high → latch operands, go DIV, iteration counter = 24.
- Accept: s = s1^s2; m1 = {1,x1[22:0]}, m2 = {1,x2[22:0]} (24 b). If m1 < m2: dividend = m1<<1, adj = 1; else adj = 0. e = e1 − e2 + 127 − adj, 10-bit signed.
- DIV: 25 cycles (counter 24..0); each cycle: rem ≥ m2 → q bit 1, rem −= m2; shift rem left 1. q = 1 integer + 23 fraction + 1 guard bit; sticky = (final rem ≠ 0).
- ROUND (1 cycle): RNE on guard/sticky/LSB; mantissa carry-out → mantissa 0, e+1. Then classify and write `y`, `ovf`, go DONE.
- Result priority: (1) x1 or x2 exponent 255 with nonzero mantissa, or 0/0, or inf/inf → don't-care (any value). (2) x1 exp 255 (inf) → {s,FF,0}, ovf=0. (3) x2 exp 0 (zero, x1 nonzero) → {s,FF,0}, ovf=0. (4) x1 exp 0 → {s,00,0}. (5) x2 inf → {s,00,0}. (6) rounded e ≥ 255 → {s,FF,0}, ovf=1. (7) e ≤ 0 → {s,00,0} (flush), ovf=0. (8) else {s,e[7:0],frac}.
- Exponent-0 inputs are zero regardless of mantissa bits.
- Special cases still traverse DIV/ROUND: fixed latency.
- DONE: `out_valid`=1, `y`/`ovf` held; `out_ready` → IDLE, `out_valid` low next cycle. `in_ready` low outside IDLE; no overlapped accept.

## Timing
- Accept on edge t0 (IDLE & `in_valid`). DIV edges t1..t25, ROUND edge t26; `out_valid` high from t27 until the edge where `out_ready` sampled high.
- Latency accept→`out_valid` = 27 cycles; min issue interval 28 cycles (`out_ready` tied high).
- `out_ready` high while not DONE: ignored.
- `rst` high at any edge, any state → IDLE next cycle; in-flight result discarded, `out_valid`=0, `in_ready`=1 after reset deasserts. `rst` dominates `in_valid`.
- `x1`/`x2` need only be valid at the accept edge.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → y=0x40400000, ovf=0, `out_valid` exactly 27 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB (round-up); 0xBF800000 / 0x40000000 → 0xBF000000 (sign).
- 0x7F000000 / 0x3E800000 → 0x7F800000, ovf=1; 0x00800000 / 0x40000000 → 0x00000000, ovf=0; 0x3F800000 / 0x00000000 → 0x7F800000, ovf=0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → y stable, `in_ready`=0, second `in_valid` not accepted; release → IDLE next cycle, second op accepted.
- Reset at DIV cycle 10 → next cycle `out_valid`=0, `in_ready`=1; new op after reset gives correct result, no stale output.
- Random sweep, all exponent pairs × signs, 10 samples each vs `$bitstoshortreal` division: bit-exact or NaN-exempt; ovf matches (ref exp 255, finite inputs, nonzero divisor).
